adder_share_arbiter: RTL and testbench

//   Shares the single WIDTH-bit adder of the tt_um top level between two operand requesters.

---
 rtl/adder_share_arbiter.sv | 58 +++++
 tb/tb_adder_share_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one adder between two requesters
// with a one-entry registered result stage tagged by requester id.
module adder_share_arbiter #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_id,
  input  logic             res_ready
);
  logic             last_grant;
  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             xfer;
  logic             sel;
  logic [WIDTH:0]   sum;
  // rst_n in can_accept keeps both readys low while reset is asserted
  assign can_accept = rst_n & ena & (!res_valid | res_ready);
  assign grant0     = req0_valid & (!req1_valid | last_grant);
  assign grant1     = req1_valid & (!req0_valid | !last_grant);
  assign req0_ready = can_accept & grant0;
  assign req1_ready = can_accept & grant1;
  assign xfer       = req0_ready | req1_ready;
  assign sel        = req1_ready;
  assign sum        = sel ? {1'b0, req1_a} + {1'b0, req1_b}
                          : {1'b0, req0_a} + {1'b0, req0_b};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_carry  <= 1'b0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      res_valid  <= 1'b1;
      res_data   <= (SAT && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      res_carry  <= sum[WIDTH];
      res_id     <= sel;
      last_grant <= sel;
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: table-driven check of the shared adder arbiter,
// with wrapping and saturating instances driven from the same stimulus.
module tb_adder_share_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_a = '0;
  logic [7:0] req0_b = '0;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_a = '0;
  logic [7:0] req1_b = '0;
  logic       res_ready = 1'b0;
  logic       w_r0, w_r1, w_v, w_c, w_id;
  logic [7:0] w_d;
  logic       s_r0, s_r1, s_v, s_c, s_id;
  logic [7:0] s_d;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(w_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(w_r1),
    .res_valid(w_v), .res_data(w_d), .res_carry(w_c), .res_id(w_id), .res_ready(res_ready)
  );

  adder_share_arbiter #(.WIDTH(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_r1),
    .res_valid(s_v), .res_data(s_d), .res_carry(s_c), .res_id(s_id), .res_ready(res_ready)
  );

  typedef struct {
    logic       en;
    logic       v0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       v1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       rr;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [7:0] od;
    logic       oc;
    logic       oid;
    logic [7:0] osd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ready(input string tag, input logic r0, input logic r1);
    chk({tag, " wrap req0_ready"}, 32'(w_r0), 32'(r0));
    chk({tag, " wrap req1_ready"}, 32'(w_r1), 32'(r1));
    chk({tag, " sat req0_ready"}, 32'(s_r0), 32'(r0));
    chk({tag, " sat req1_ready"}, 32'(s_r1), 32'(r1));
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [7:0] d,
                         input logic c, input logic id, input logic [7:0] sd);
    chk({tag, " wrap res_valid"}, 32'(w_v), 32'(v));
    chk({tag, " wrap res_data"}, 32'(w_d), 32'(d));
    chk({tag, " wrap res_carry"}, 32'(w_c), 32'(c));
    chk({tag, " wrap res_id"}, 32'(w_id), 32'(id));
    chk({tag, " sat res_valid"}, 32'(s_v), 32'(v));
    chk({tag, " sat res_data"}, 32'(s_d), 32'(sd));
    chk({tag, " sat res_carry"}, 32'(s_c), 32'(c));
    chk({tag, " sat res_id"}, 32'(s_id), 32'(id));
  endtask

  initial begin
    //                 en v0 a0     b0     v1 a1     b1     rr r0 r1 ov od     oc id sd
    vecs.push_back(vec_t'{1, 1, 8'h12, 8'h34, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'h46, 0, 0, 8'h46});
    vecs.push_back(vec_t'{1, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1, 0, 1, 1, 8'h30, 0, 1, 8'h30});
    vecs.push_back(vec_t'{1, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1, 1, 0, 1, 8'h03, 0, 0, 8'h03});
    vecs.push_back(vec_t'{1, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1, 0, 1, 1, 8'h30, 0, 1, 8'h30});
    vecs.push_back(vec_t'{1, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1, 1, 0, 1, 8'h03, 0, 0, 8'h03});
    vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 1, 8'hF0, 8'h20, 1, 0, 1, 1, 8'h10, 1, 1, 8'hFF});
    vecs.push_back(vec_t'{1, 1, 8'h12, 8'h34, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'h46, 0, 0, 8'h46});
    vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 1, 8'h05, 8'h06, 0, 0, 0, 1, 8'h46, 0, 0, 8'h46});
    vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 1, 8'h05, 8'h06, 0, 0, 0, 1, 8'h46, 0, 0, 8'h46});
    vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 1, 8'h05, 8'h06, 0, 0, 0, 1, 8'h46, 0, 0, 8'h46});
    vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 1, 8'h05, 8'h06, 1, 0, 1, 1, 8'h0B, 0, 1, 8'h0B});
    vecs.push_back(vec_t'{0, 1, 8'h07, 8'h08, 1, 8'h09, 8'h0A, 1, 0, 0, 0, 8'h0B, 0, 1, 8'h0B});
    vecs.push_back(vec_t'{0, 1, 8'h07, 8'h08, 1, 8'h09, 8'h0A, 1, 0, 0, 0, 8'h0B, 0, 1, 8'h0B});
    vecs.push_back(vec_t'{0, 1, 8'h07, 8'h08, 1, 8'h09, 8'h0A, 1, 0, 0, 0, 8'h0B, 0, 1, 8'h0B});
    vecs.push_back(vec_t'{0, 1, 8'h07, 8'h08, 1, 8'h09, 8'h0A, 1, 0, 0, 0, 8'h0B, 0, 1, 8'h0B});
    vecs.push_back(vec_t'{1, 1, 8'h07, 8'h08, 1, 8'h09, 8'h0A, 1, 1, 0, 1, 8'h0F, 0, 0, 8'h0F});
    vecs.push_back(vec_t'{1, 1, 8'h07, 8'h08, 1, 8'h09, 8'h0A, 0, 0, 0, 1, 8'h0F, 0, 0, 8'h0F});
    vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h0F, 0, 0, 8'h0F});
    vecs.push_back(vec_t'{1, 1, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'h00, 1, 0, 8'hFF});
    vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 1, 8'h80, 8'h7F, 1, 0, 1, 1, 8'hFF, 0, 1, 8'hFF});

    // reset state, with a pending request that must not see ready
    ena = 1'b1;
    req0_valid = 1'b1;
    #12;
    chk_ready("reset", 1'b0, 1'b0);
    chk_res("reset", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      ena = vecs[i].en;
      req0_valid = vecs[i].v0;
      req0_a = vecs[i].a0;
      req0_b = vecs[i].b0;
      req1_valid = vecs[i].v1;
      req1_a = vecs[i].a1;
      req1_b = vecs[i].b1;
      res_ready = vecs[i].rr;
      #1;
      chk_ready(tag, vecs[i].r0, vecs[i].r1);
      @(posedge clk);
      #1;
      chk_res(tag, vecs[i].ov, vecs[i].od, vecs[i].oc, vecs[i].oid, vecs[i].osd);
    end

    // stage is FULL (id 1) here; async reset mid-cycle must clear it before the next edge
    req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h31; req1_b = 8'h32;
    res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_res("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk_ready("async_rst", 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    chk_ready("post_rst tie", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_res("post_rst tie", 1'b1, 8'h43, 1'b0, 1'b0, 8'h43);
    #1;
    chk_ready("post_rst next", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_res("post_rst next", 1'b1, 8'h63, 1'b0, 1'b1, 8'h63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
